// File: rtl/scalar_mem_responder_pkg.sv
// Shared scalar-unit memory interface types: data word and RAM port status.
package scalar_mem_responder_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 4;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/scalar_mem_responder.sv
// Word-addressed memory slave for the scalar FU RAM port with programmable
// access latency; status reported on ramstate, read data held on ramload.
module scalar_mem_responder
  import scalar_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 2
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      ren,
  input  logic      wen,
  input  word_t     ramaddr,
  input  word_t     ramstore,
  output word_t     ramload,
  output ramstate_t ramstate
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_ERR
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  word_t               data_q, data_d;
  word_t               ramload_q, ramload_d;
  ramstate_t           ramstate_q, ramstate_d;
  word_t               mem_q [DEPTH];

  logic                acc_en_c;
  logic                acc_we_c;
  logic [ADDR_W-1:0]   acc_addr_c;
  word_t               acc_data_c;
  logic                out_of_range_c;

  assign out_of_range_c = (ramaddr >> ADDR_W) != '0;

  // Next-state, latch capture and the memory access performed on entry to ACCESS
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    data_d     = data_q;
    acc_en_c   = 1'b0;
    acc_we_c   = we_q;
    acc_addr_c = addr_q;
    acc_data_c = data_q;

    unique case (state_q)
      S_IDLE: begin
        if (ren && wen) begin
          state_d = S_ERR;
        end else if (ren ^ wen) begin
          if (out_of_range_c) begin
            state_d = S_ERR;
          end else begin
            we_d   = wen;
            addr_d = ramaddr[ADDR_W-1:0];
            data_d = ramstore;
            if (LATENCY == 1) begin
              // Single-cycle build: access uses the live request directly
              state_d    = S_ACCESS;
              acc_en_c   = 1'b1;
              acc_we_c   = wen;
              acc_addr_c = ramaddr[ADDR_W-1:0];
              acc_data_c = ramstore;
            end else begin
              state_d = S_WAIT;
              cnt_d   = CNT_W'(LATENCY - 1);
            end
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = S_ACCESS;
          acc_en_c = 1'b1;
        end
      end
      S_ACCESS: state_d = S_IDLE;
      S_ERR:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ramload_d = ramload_q;
    if (acc_en_c && !acc_we_c) begin
      ramload_d = mem_q[acc_addr_c];
    end
  end

  always_comb begin
    ramstate_d = FREE;
    unique case (state_d)
      S_IDLE:   ramstate_d = FREE;
      S_WAIT:   ramstate_d = BUSY;
      S_ACCESS: ramstate_d = ACCESS;
      S_ERR:    ramstate_d = ERROR;
      default:  ramstate_d = FREE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      ramload_q  <= '0;
      ramstate_q <= FREE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      ramload_q  <= ramload_d;
      ramstate_q <= ramstate_d;
    end
  end

  // Storage array; cleared on reset so an in-flight write is lost
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (acc_en_c && acc_we_c) begin
      mem_q[acc_addr_c] <= acc_data_c;
    end
  end

  assign ramload  = ramload_q;
  assign ramstate = ramstate_q;

endmodule

// File: tb/tb_scalar_mem_responder.sv
// Directed bench for scalar_mem_responder: LATENCY=2, 4 and 1 builds share
// one request bus; each phase checks only the instance it targets.
module tb_scalar_mem_responder;
  import scalar_mem_responder_pkg::*;

  logic      CLK = 1'b0;
  logic      nRST = 1'b0;
  logic      ren = 1'b0;
  logic      wen = 1'b0;
  word_t     ramaddr = '0;
  word_t     ramstore = '0;
  word_t     ld2, ld4, ld1;
  ramstate_t st2, st4, st1;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 CLK = ~CLK;

  scalar_mem_responder #(.ADDR_W(8), .LATENCY(2)) u_l2 (
    .CLK(CLK), .nRST(nRST), .ren(ren), .wen(wen), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ld2), .ramstate(st2)
  );

  scalar_mem_responder #(.ADDR_W(8), .LATENCY(4)) u_l4 (
    .CLK(CLK), .nRST(nRST), .ren(ren), .wen(wen), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ld4), .ramstate(st4)
  );

  scalar_mem_responder #(.ADDR_W(8), .LATENCY(1)) u_l1 (
    .CLK(CLK), .nRST(nRST), .ren(ren), .wen(wen), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ld1), .ramstate(st1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input word_t a, input word_t d);
    ren      = r;
    wen      = w;
    ramaddr  = a;
    ramstore = d;
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  // One LATENCY=2 transaction: request held for a single sampling edge
  task automatic txn2(input string tag, input logic r, input logic w, input word_t a,
                      input word_t d, input logic err, input word_t exp_load);
    drive(r, w, a, d);
    step();
    drive(1'b0, 1'b0, '0, '0);
    if (!err) begin
      chk({tag, " busy"}, 32'(st2), 32'(BUSY));
      step();
      chk({tag, " access"}, 32'(st2), 32'(ACCESS));
    end else begin
      chk({tag, " error"}, 32'(st2), 32'(ERROR));
    end
    chk({tag, " load"}, ld2, exp_load);
    step();
    chk({tag, " free"}, 32'(st2), 32'(FREE));
  endtask

  initial begin
    #3;
    chk("rst st2", 32'(st2), 32'(FREE));
    chk("rst ld2", ld2, 32'd0);
    chk("rst st4", 32'(st4), 32'(FREE));
    chk("rst st1", 32'(st1), 32'(FREE));
    step();
    nRST = 1'b1;

    txn2("rd1", 1'b1, 1'b0, 32'd1, '0, 1'b0, 32'd0);
    txn2("rd2", 1'b1, 1'b0, 32'd2, '0, 1'b0, 32'd0);
    txn2("rd4", 1'b1, 1'b0, 32'd4, '0, 1'b0, 32'd0);
    txn2("wr3", 1'b0, 1'b1, 32'd3, 32'd555, 1'b0, 32'd0);
    txn2("rd3", 1'b1, 1'b0, 32'd3, '0, 1'b0, 32'd555);
    txn2("rd4b", 1'b1, 1'b0, 32'd4, '0, 1'b0, 32'd0);
    txn2("conflict", 1'b1, 1'b1, 32'd3, 32'd999, 1'b1, 32'd0);
    txn2("rd3b", 1'b1, 1'b0, 32'd3, '0, 1'b0, 32'd555);
    txn2("oor300", 1'b1, 1'b0, 32'd300, '0, 1'b1, 32'd555);

    // Let the LATENCY=4 instance drain the shared traffic
    repeat (6) step();
    chk("l4 idle", 32'(st4), 32'(FREE));

    drive(1'b0, 1'b1, 32'd7, 32'h0000_DEAD);
    step();
    drive(1'b0, 1'b0, '0, '0);
    chk("l4 wr busy1", 32'(st4), 32'(BUSY));
    step();
    chk("l4 wr busy2", 32'(st4), 32'(BUSY));
    nRST = 1'b0;
    #1;
    chk("l4 rst free", 32'(st4), 32'(FREE));
    chk("l2 rst load", ld2, 32'd0);
    #1;
    nRST = 1'b1;
    step();

    drive(1'b1, 1'b0, 32'd7, '0);
    step();
    drive(1'b0, 1'b0, '0, '0);
    chk("l4 rd busy1", 32'(st4), 32'(BUSY));
    step();
    chk("l4 rd busy2", 32'(st4), 32'(BUSY));
    step();
    chk("l4 rd busy3", 32'(st4), 32'(BUSY));
    step();
    chk("l4 rd access", 32'(st4), 32'(ACCESS));
    chk("l4 rd7 load", ld4, 32'd0);
    step();
    chk("l4 rd free", 32'(st4), 32'(FREE));

    drive(1'b0, 1'b1, 32'd5, 32'h0000_1234);
    step();
    drive(1'b0, 1'b0, '0, '0);
    chk("l1 wr access", 32'(st1), 32'(ACCESS));
    chk("l1 wr load", ld1, 32'd0);
    step();
    chk("l1 wr free", 32'(st1), 32'(FREE));

    drive(1'b1, 1'b0, 32'd5, '0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("l1 rd access", 32'(st1), 32'(ACCESS));
      chk("l1 rd load", ld1, 32'h0000_1234);
      step();
      chk("l1 rd free", 32'(st1), 32'(FREE));
    end
    drive(1'b0, 1'b0, '0, '0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scalar_mem_responder.md
# scalar_mem_responder

Word-addressed synchronous memory responder serving the scalar functional unit's RAM port (`ren`/`wen`/`ramaddr`/`ramstore` in, `ramload` out). Each accepted request completes after a configurable number of wait cycles, and completion is reported on a `ramstate` status output. It is the slave end of the scalar memory interface. It lets the scalar FU and its testbenches run against realistic memory latency instead of a zero-wait array.

## Interface
- `ADDR_W`, default 8: word-address width; memory depth is 2**ADDR_W words of `word_t`.
- `LATENCY`, default 2: cycles from request sample to completion. Legal range is 1..15.
- `CLK`  in  1: clock; all state changes on the rising edge.
- `nRST`  in  1: reset. One clock; reset is asynchronous and active-low.
- `ren`  in  1: read request.
- `wen`  in  1: write request.
- `ramaddr`  in  32 (`word_t`): word address.
- `ramstore`  in  32 (`word_t`): write data.
- `ramload`  out  32 (`word_t`): read data, registered and held between reads.
- `ramstate`  out  2 (`ramstate_t`): registered status. FREE=0, BUSY=1, ACCESS=2, ERROR=3.

## Operation
- **FSM states:** IDLE, WAIT, ACCESS, ERR. `ramstate` encodes the state as follows:
  - IDLE→FREE
  - WAIT→BUSY
  - ACCESS→ACCESS
  - ERR→ERROR
- **IDLE**, at each edge, in priority order:
  1. `ren & wen` → ERR.
  2. `(ren ^ wen)` with `ramaddr >= 2**ADDR_W` (any upper bit set) → ERR.
  3. `(ren ^ wen)` in range → latch op, address[ADDR_W-1:0] and `ramstore`.
     - If LATENCY==1, go to ACCESS.
     - Otherwise go to WAIT with `cnt = LATENCY-1`.
  4. Neither request → stay IDLE.
- **WAIT:**
  - Request inputs are ignored; only latched copies are used.
  - Each edge decrements `cnt`.
  - The edge at which `cnt==1` moves the FSM to ACCESS.
- **Entering ACCESS** (same edge):
  - Write: `mem[addr] <= data`.
  - Read: `ramload <= mem[addr]`.
  - A write does not change `ramload`.
- **ACCESS and ERR** last exactly one cycle and always return to IDLE. Inputs during these cycles are ignored.
- **ERR:** no memory or `ramload` change.
- **Initiator rule:** after seeing ACCESS or ERROR, the initiator deasserts or changes its request. A request still held in the following IDLE cycle is treated as a new request.
- **Memory:** flop array, cleared to 0 on reset.

## Timing
- **Reset values:**
  - `ramstate` = FREE
  - `ramload` = 0
  - `cnt` = 0
  - all memory words = 0
- **Reset mid-operation:** asynchronous and immediate. A pending WAIT write is discarded and memory is cleared.
- **Latency:** a request sampled at edge k gives ACCESS in the cycle after edge k+LATENCY-1, i.e. `ramstate` reads ACCESS LATENCY cycles after the sampling edge. `ramload` is valid in that same cycle and held afterwards.
- **BUSY duration:** LATENCY-1 cycles; zero when LATENCY=1.
- **ERROR:** appears in the cycle after the sampling edge.
- **Throughput:** one access per LATENCY+1 cycles (the IDLE cycle is mandatory).
- **Read-after-write** to the same address returns the new data.
- **Address handling:** `ramaddr` bits above ADDR_W participate only in the range check.

## Structure
- **Shared package** (existing scalar-unit types include):
  - `word_t` (32-bit).
  - `ramstate_t` enum with FREE/BUSY/ACCESS/ERROR.
- **Local to this module:** the FSM state enum.
- **Sub-module:** none required. A single module holds the FSM, the down-counter, the latch registers and the array.

## Test plan
- **Reset then read:** assert `nRST`=0 for one period, then read addresses 1, 2, 4 (LATENCY=2).
  - Each read gives BUSY for 1 cycle, then ACCESS with `ramload`=0.
  - FREE between reads.
- **Write then read:** write 555 to address 3, then read address 3.
  - Write: BUSY then ACCESS; `ramload` unchanged.
  - Read: ACCESS with `ramload`=555.
  - A read of address 4 returns 0.
- **Conflict:** `ren=wen=1`, address 3.
  - ERROR for one cycle, then FREE.
  - A subsequent read of 3 still returns 555.
- **Out of range:** read address 300 with ADDR_W=8.
  - ERROR for one cycle; `ramload` holds its previous value.
- **Reset during WAIT:** write 0xDEAD to address 7 (LATENCY=4); pulse `nRST` low during the BUSY phase.
  - `ramstate`=FREE immediately.
  - A later read of 7 returns 0.
- **LATENCY=1 build:** continuous `ren` on address 5.
  - `ramstate` alternates ACCESS/FREE every cycle with no BUSY.
  - `ramload` updates on each ACCESS.
